// File: rtl/pingpong_drain_sched.sv
// Drains the ping-pong buffer that RX is not writing, sends its bytes as a stream, then appends an 8-bit checksum byte.
// Latency: read strobe 1 cycle after SWAP_PULSE, first TX_VALID 3 cycles after it; steady rate 1 byte / 3 cycles.
// Backpressure: TX_VALID/TX_DATA hold until TX_READY; no FIFO read is issued while a byte is waiting to be accepted.
module pingpong_drain_sched #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             W_FLAG,
    input  logic             SWAP_PULSE,
    input  logic             FIFO1_EMPTY,
    input  logic             FIFO2_EMPTY,
    output logic             FIFO1_RD,
    output logic             FIFO2_RD,
    input  logic [7:0]       FIFO1_DOUT,
    input  logic [7:0]       FIFO2_DOUT,
    output logic             TX_VALID,
    output logic [7:0]       TX_DATA,
    input  logic             TX_READY,
    output logic             COMPLE,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic [CNT_W-1:0] BYTE_CNT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        CSUM  = 3'd4,
        CSEND = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t           state;
    logic             sel;       // 1: drain FIFO1, 0: drain FIFO2
    logic [7:0]       csum;
    logic [CNT_W-1:0] byte_cnt;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             comple;
    logic             overrun;

    logic             sel_empty;
    logic [7:0]       sel_dout;
    logic             rd_stop;
    logic             rd_go;
    logic             tx_fire;

    // Steer the latched buffer's flags/data and decide whether RD issues a read.
    // The strobe is decoded from state so it lands in the RD cycle itself using the
    // live empty flag, which a one-cycle-early registered strobe could not see.
    always_comb begin
        sel_empty = sel ? FIFO1_EMPTY : FIFO2_EMPTY;
        sel_dout  = sel ? FIFO1_DOUT  : FIFO2_DOUT;
        rd_stop   = sel_empty || (byte_cnt == CNT_W'(MAX_LEN));
        rd_go     = (state == RD) && !rd_stop;
        tx_fire   = tx_valid && TX_READY;
    end

    assign FIFO1_RD = rd_go && sel;
    assign FIFO2_RD = rd_go && !sel;
    assign TX_VALID = tx_valid;
    assign TX_DATA  = tx_data;
    assign COMPLE   = comple;
    assign BUSY     = (state != IDLE);
    assign OVERRUN  = overrun;
    assign BYTE_CNT = byte_cnt;

    // Frame sequencer: read, load, send per byte, then checksum byte and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            csum     <= 8'd0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
            comple   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            comple  <= 1'b0;
            // A swap can only start a frame from IDLE; anywhere else it is flagged and dropped.
            overrun <= SWAP_PULSE && (state != IDLE);
            case (state)
                IDLE: begin
                    if (SWAP_PULSE) begin
                        sel      <= W_FLAG;
                        byte_cnt <= '0;
                        csum     <= 8'd0;
                        state    <= RD;
                    end
                end
                RD: begin
                    if (rd_stop) begin
                        if (byte_cnt == '0) begin
                            comple <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CSUM;
                        end
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data  <= sel_dout;
                    tx_valid <= 1'b1;
                    csum     <= csum + sel_dout;
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        state    <= RD;
                    end
                end
                CSUM: begin
                    tx_data  <= csum;
                    tx_valid <= 1'b1;
                    state    <= CSEND;
                end
                CSEND: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        comple   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
